// File: rtl/spi_arb_pkg.sv
// spi_arb_pkg: shared FSM type, SPI mode constants and arbitration helpers
// used by spi_txn_arbiter and spi_shift_engine.
package spi_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        GAP
    } arb_state_e;

    // Mode 0: sclk idles low, data sampled on the leading (rising) edge.
    localparam logic SPI_CPOL = 1'b0;
    localparam logic SPI_CPHA = 1'b0;

    localparam int MAX_REQ = 32;

    // Winner is the set bit at the smallest rotation distance past last.
    function automatic logic [MAX_REQ-1:0] rr_pick(
        input logic [MAX_REQ-1:0] req,
        input int                 last,
        input int                 n
    );
        logic [MAX_REQ-1:0] gnt;
        int                 best;
        gnt  = '0;
        best = n;
        for (int i = 0; i < MAX_REQ; i++) begin
            if (i < n && req[i] && ((i + n - last - 1) % n) < best) begin
                best = (i + n - last - 1) % n;
            end
        end
        for (int i = 0; i < MAX_REQ; i++) begin
            gnt[i] = (i < n) && req[i] && (((i + n - last - 1) % n) == best);
        end
        return gnt;
    endfunction

    function automatic logic [MAX_REQ-1:0] fixed_pick(
        input logic [MAX_REQ-1:0] req
    );
        return req & (~req + MAX_REQ'(1));
    endfunction

endpackage

// File: rtl/spi_shift_engine.sv
// spi_shift_engine: sclk divider, MSB-first mosi shifter, miso sampler
// and bit counter for one mode-0 word transfer.
module spi_shift_engine
    import spi_arb_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int CLK_DIV = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic              start,
    input  logic              stop,
    input  logic [DATA_W-1:0] word_in,
    input  logic              miso,
    output logic              tick,
    output logic              finished,
    output logic              sclk,
    output logic              mosi,
    output logic [DATA_W-1:0] word_out
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BW = $clog2(DATA_W + 1);

    logic [CW-1:0]     div_cnt;
    logic [BW-1:0]     bit_cnt;
    logic [DATA_W-2:0] tx_q;
    logic [DATA_W-1:0] rx_q;
    logic              active;
    logic              sclk_q;
    logic              mosi_q;
    logic              sample_edge;

    assign tick        = run && (div_cnt == CW'(CLK_DIV - 1));
    assign sample_edge = (sclk_q == (SPI_CPOL ^ SPI_CPHA));
    assign finished    = active && tick && !sample_edge
                         && (bit_cnt == BW'(DATA_W - 1));

    assign sclk     = sclk_q;
    assign mosi     = mosi_q;
    assign word_out = rx_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= '0;
            bit_cnt <= '0;
            tx_q    <= '0;
            rx_q    <= '0;
            active  <= 1'b0;
            sclk_q  <= SPI_CPOL;
            mosi_q  <= 1'b0;
        end else begin
            if (!run || tick) begin
                div_cnt <= '0;
            end else begin
                div_cnt <= div_cnt + CW'(1);
            end
            if (start) begin
                tx_q    <= word_in[DATA_W-2:0];
                mosi_q  <= word_in[DATA_W-1];
                bit_cnt <= '0;
                active  <= 1'b1;
                sclk_q  <= SPI_CPOL;
            end else if (stop) begin
                mosi_q <= 1'b0;
            end else if (active && tick) begin
                sclk_q <= ~sclk_q;
                if (sample_edge) begin
                    rx_q <= {rx_q[DATA_W-2:0], miso};
                end else begin
                    bit_cnt <= bit_cnt + BW'(1);
                    // The final bit stays on mosi through the hold phase.
                    if (finished) begin
                        active <= 1'b0;
                    end else begin
                        mosi_q <= tx_q[DATA_W-2];
                        tx_q   <= tx_q << 1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/spi_txn_arbiter.sv
// spi_txn_arbiter: shares one mode-0 SPI master among NUM_REQ requesters.
// Define SPI_ARB_FIXED_PRIO_EN for lowest-index-wins instead of round-robin.
module spi_txn_arbiter
    import spi_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int DATA_W  = 16,
    parameter int CLK_DIV = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] wr_data,
    output logic [NUM_REQ-1:0]        grant,
    output logic [NUM_REQ-1:0]        done,
    output logic [DATA_W-1:0]         rd_data,
    output logic                      busy,
    output logic                      sclk,
    output logic                      mosi,
    input  logic                      miso,
    output logic                      ss
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    arb_state_e        state;
    arb_state_e        state_nxt;
    logic [NUM_REQ-1:0] pick;
    logic [IW-1:0]     pick_idx;
    logic              start;
    logic              stop;
    logic              run;
    logic              tick;
    logic              finished;
    logic [DATA_W-1:0] word_out;

`ifdef SPI_ARB_FIXED_PRIO_EN
    assign pick = NUM_REQ'(fixed_pick(MAX_REQ'(req)));
`else
    logic [IW-1:0] last_grant;
    logic [IW-1:0] grant_idx;

    assign pick = NUM_REQ'(rr_pick(MAX_REQ'(req), int'(last_grant), NUM_REQ));

    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) grant_idx = IW'(i);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= IW'(NUM_REQ - 1);
        end else if (stop) begin
            last_grant <= grant_idx;
        end
    end
`endif

    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick[i]) pick_idx = IW'(i);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (|req)    state_nxt = SETUP;
            SETUP:   if (tick)    state_nxt = SHIFT;
            SHIFT:   if (finished) state_nxt = HOLD;
            HOLD:    if (tick)    state_nxt = GAP;
            GAP:     if (tick)    state_nxt = IDLE;
            default:              state_nxt = IDLE;
        endcase
    end

    always_comb begin
        start = 1'b0;
        stop  = 1'b0;
        run   = 1'b1;
        unique case (state)
            IDLE: begin
                run   = 1'b0;
                start = |req;
            end
            HOLD:    stop = tick;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            grant   <= '0;
            done    <= '0;
            rd_data <= '0;
            ss      <= 1'b1;
        end else begin
            done <= '0;
            if (start) begin
                grant <= pick;
                ss    <= 1'b0;
            end
            if (stop) begin
                grant   <= '0;
                done    <= grant;
                rd_data <= word_out;
                ss      <= 1'b1;
            end
        end
    end

    assign busy = (state != IDLE);

    spi_shift_engine #(
        .DATA_W  (DATA_W),
        .CLK_DIV (CLK_DIV)
    ) u_engine (
        .clk      (clk),
        .rst      (rst),
        .run      (run),
        .start    (start),
        .stop     (stop),
        .word_in  (wr_data[int'(pick_idx) * DATA_W +: DATA_W]),
        .miso     (miso),
        .tick     (tick),
        .finished (finished),
        .sclk     (sclk),
        .mosi     (mosi),
        .word_out (word_out)
    );

endmodule

// File: tb/tb_spi_txn_arbiter.sv
// tb_spi_txn_arbiter: randomized frame-level model check of spi_txn_arbiter
// plus directed cases and a CLK_DIV=1 / DATA_W=8 loopback instance.
module tb_spi_txn_arbiter;

    localparam int NR  = 2;
    localparam int DW  = 16;
    localparam int H   = 4;
    localparam int SSL = (2 * DW + 1) * H;
    localparam int FR  = (2 * DW + 2) * H;
    localparam int LIM = 1000;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [NR-1:0]    req = '0;
    logic [NR*DW-1:0] wr_data = '0;
    logic [NR-1:0]    grant;
    logic [NR-1:0]    done;
    logic [DW-1:0]    rd_data;
    logic             busy;
    logic             sclk;
    logic             mosi;
    logic             miso = 1'b0;
    logic             ss;

    logic [1:0]       req2 = '0;
    logic [15:0]      wr2 = '0;
    logic [1:0]       grant2;
    logic [1:0]       done2;
    logic [7:0]       rd2;
    logic             busy2;
    logic             sclk2;
    logic             mosi2;
    logic             ss2;
    logic [7:0]       rx2 = '0;

    int vecs = 0;
    int errs = 0;

    always #5 clk = ~clk;

    spi_txn_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .CLK_DIV(H)) dut (
        .clk(clk), .rst(rst), .req(req), .wr_data(wr_data),
        .grant(grant), .done(done), .rd_data(rd_data), .busy(busy),
        .sclk(sclk), .mosi(mosi), .miso(miso), .ss(ss)
    );

    spi_txn_arbiter #(.NUM_REQ(2), .DATA_W(8), .CLK_DIV(1)) dut_min (
        .clk(clk), .rst(rst), .req(req2), .wr_data(wr2),
        .grant(grant2), .done(done2), .rd_data(rd2), .busy(busy2),
        .sclk(sclk2), .mosi(mosi2), .miso(mosi2), .ss(ss2)
    );

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Slave BFM: presents its word MSB first from ss fall, next bit after
    // each sclk fall; captures mosi on sclk rise.
    logic [DW-1:0] next_sw = '0;
    logic [DW-1:0] sl_tx = '0;
    logic [DW-1:0] sl_rx = '0;
    logic          sl_busy = 1'b0;
    int            sl_n = 0;

    always @(ss or negedge sclk) begin
        if (ss !== 1'b0) begin
            sl_busy = 1'b0;
        end else if (!sl_busy) begin
            sl_busy = 1'b1;
            sl_tx   = next_sw;
            sl_n    = 0;
        end else begin
            sl_n++;
        end
        miso = sl_tx[DW - 1 - ((sl_n < DW) ? sl_n : DW - 1)];
    end

    always @(posedge sclk) if (ss === 1'b0) sl_rx = {sl_rx[DW-2:0], mosi};
    always @(posedge sclk2) if (ss2 === 1'b0) rx2 = {rx2[6:0], mosi2};

    // Frame-level reference: one frame = fixed timeline measured from grant.
    logic          m_act = 1'b0;
    int            m_k = 0;
    int            m_own = 0;
    int            m_last = NR - 1;
    logic [DW-1:0] m_word = '0;
    logic [DW-1:0] m_sw = '0;
    logic [DW-1:0] m_rd = '0;

    function automatic int pick_model(input logic [NR-1:0] r, input int last);
`ifdef SPI_ARB_FIXED_PRIO_EN
        for (int i = 0; i < NR; i++) if (r[i]) return i;
`else
        for (int i = 1; i <= NR; i++) if (r[(last + i) % NR]) return (last + i) % NR;
`endif
        return 0;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_act  = 1'b0;
            m_last = NR - 1;
            m_rd   = '0;
        end else if (m_act) begin
            m_k++;
            if (m_k == SSL) begin
                m_rd   = m_sw;
                m_last = m_own;
            end
            if (m_k == FR) m_act = 1'b0;
        end else if (req != '0) begin
            m_own  = pick_model(req, m_last);
            m_act  = 1'b1;
            m_k    = 0;
            m_word = wr_data[m_own * DW +: DW];
            m_sw   = next_sw;
        end
    end

    logic [NR-1:0] eg;
    logic [NR-1:0] ed;
    logic          es;
    logic          eb;
    logic          esc;
    logic          em;
    int            bi;

    always @(negedge clk) begin
        eg = '0; ed = '0; es = 1'b1; eb = 1'b0; esc = 1'b0; em = 1'b0;
        if (m_act) begin
            eb = 1'b1;
            if (m_k < SSL) begin
                eg[m_own] = 1'b1;
                es  = 1'b0;
                esc = (m_k >= H) && (((m_k / H) % 2) == 1);
                bi  = m_k / (2 * H);
                if (bi > DW - 1) bi = DW - 1;
                em  = m_word[DW - 1 - bi];
            end
            if (m_k == SSL) ed[m_own] = 1'b1;
        end
        vecs++;
        if ({grant, done, rd_data, busy, ss, sclk, mosi} !==
            {eg, ed, m_rd, eb, es, esc, em}) begin
            errs++;
            $display("FAIL cycle t=%0t grant=%b/%b done=%b/%b rd=%h/%h busy=%b/%b ss=%b/%b sclk=%b/%b mosi=%b/%b",
                     $time, grant, eg, done, ed, rd_data, m_rd, busy, eb,
                     ss, es, sclk, esc, mosi, em);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    int n;
    int ss_low;
    int rises;
    int tog;
    logic prev;
    logic [NR-1:0] g;
    logic [NR-1:0] exp_g;

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_grant", grant, 0);
        chk("rst_ss", ss, 1);
        chk("rst_busy", busy, 0);
        chk("rst_rd", rd_data, 0);

        // Single transfer
        wr_data = {16'h1234, 16'hA5A5};
        next_sw = 16'h3C3C;
        req = 2'b01;
        @(negedge clk);
        chk("lat_grant", grant, 2'b01);
        chk("lat_ss", ss, 0);
        ss_low = 0; n = 0;
        while (done == '0 && n < LIM) begin
            if (!ss) ss_low++;
            @(negedge clk);
            n++;
        end
        req = 2'b00;
        chk("single_to", 32'(n < LIM), 1);
        chk("single_done", done, 2'b01);
        chk("single_rd", rd_data, 16'h3C3C);
        chk("single_ss_low", 32'(ss_low), 132);
        chk("single_mosi", sl_rx, 16'hA5A5);
        chk("model_rd", m_rd, 16'h3C3C);

        // Contention from a fresh reset
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        req = 2'b11;
        wr_data = {16'hC0DE, 16'hBEEF};
        next_sw = 16'h0F0F;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            while (grant == '0 && n < LIM) begin @(negedge clk); n++; end
            g = grant;
`ifdef SPI_ARB_FIXED_PRIO_EN
            exp_g = 2'b01;
`else
            exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
`endif
            chk("cont_grant", g, exp_g);
            n = 0;
            while (done == '0 && n < LIM) begin @(negedge clk); n++; end
            chk("cont_done", done, g);
        end
        req = 2'b00;
        n = 0;
        while (busy && n < LIM) begin @(negedge clk); n++; end

        // Reset after the 5th sclk rise
        req = 2'b01; rises = 0; prev = 1'b0; n = 0;
        while (rises < 5 && n < LIM) begin
            @(negedge clk);
            n++;
            if (sclk && !prev) rises++;
            prev = sclk;
        end
        chk("rst_mid_rises", 32'(rises), 5);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_ss", ss, 1);
        chk("rst_mid_sclk", sclk, 0);
        chk("rst_mid_mosi", mosi, 0);
        chk("rst_mid_grant", grant, 0);
        chk("rst_mid_done", done, 0);
        rst = 1'b0;
        req = 2'b10;
        @(negedge clk);
        chk("post_rst_grant", grant, 2'b10);

        // Request withdrawn two cycles after grant
        @(negedge clk);
        @(negedge clk);
        req = 2'b00;
        n = 0;
        while (done == '0 && n < LIM) begin @(negedge clk); n++; end
        chk("withdraw_done", done, 2'b10);

        // Randomized traffic
        for (int c = 0; c < 5000; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 15) == 0) req = NR'($urandom);
            if ($urandom_range(0, 7) == 0) begin
                for (int i = 0; i < NR; i++) wr_data[i * DW +: DW] = DW'($urandom);
            end
            if ($urandom_range(0, 7) == 0) next_sw = DW'($urandom);
            rst = ($urandom_range(0, 1999) == 0);
        end
        rst = 1'b0;
        req = '0;
        @(negedge clk);

        // Minimum divider, loopback miso
        req2 = 2'b01;
        wr2 = 16'h0081;
        @(negedge clk);
        chk("min_grant", grant2, 2'b01);
        prev = 1'b0; tog = 0; n = 0;
        while (done2 == '0 && n < LIM) begin
            if (sclk2 !== prev) tog++;
            prev = sclk2;
            @(negedge clk);
            n++;
        end
        req2 = 2'b00;
        chk("min_done", done2, 2'b01);
        chk("min_toggles", 32'(tog), 16);
        chk("min_slave_rx", rx2, 8'h81);
        chk("min_rd", rd2, 8'h81);

        repeat (FR + 4) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/spi_txn_arbiter.md
# spi_txn_arbiter

Synthesizable SPI transaction controller. It lets several on-chip requesters share one SPI bus (sclk/mosi/miso/ss) that drives a single external slave. It accepts one fixed-width word transfer per request and arbitrates round-robin between requesters. It sequences the mode-0 (CPOL=0, CPHA=0) bit timing through an internal shift engine, then returns the read word with a per-requester done pulse. It sits between the host logic and the pins, in the position the team's SPI master BFM occupies in simulation, so it can be checked directly against the slave BFM.

## Interface
Parameters:
- NUM_REQ, 2: number of requesters, minimum 1.
- DATA_W, 16: bits per transfer, MSB first, minimum 2.
- CLK_DIV, 4: system clocks per sclk half-period (H), minimum 1.

Ports:
- clk  in  1  system clock; all logic runs on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  NUM_REQ  per-requester transfer request, level; held until done.
- wr_data  in  NUM_REQ*DATA_W  per-requester write word; slice i belongs to req[i].
- grant  out  NUM_REQ  one-hot owner of the current transaction; 0 when idle.
- done  out  NUM_REQ  one-cycle pulse to the owner when the transaction ends.
- rd_data  out  DATA_W  word shifted in from miso; valid while done is nonzero, held until the next done.
- busy  out  1  high from grant through the end of the inter-frame gap.
- sclk  out  1  SPI clock, idles low.
- mosi  out  1  SPI data out.
- miso  in  1  SPI data in.
- ss  out  1  slave select, active low.

## Operation
- FSM states: IDLE, SETUP, SHIFT, HOLD, GAP.
- IDLE: if any req bit is set, select the winner by round-robin. The search starts at last_grant+1 and wraps modulo NUM_REQ. On the same edge:
  - register grant;
  - capture the winner's wr_data slice into the shift register;
  - drive ss=0 and mosi=MSB;
  - set busy=1;
  - go to SETUP.
- SETUP: wait H cycles, then raise sclk and go to SHIFT.
- SHIFT: toggle sclk every H cycles.
  - Rising edge: sample miso into the LSB of the receive register.
  - Falling edge: shift, so mosi presents the next bit.
  - After the DATA_W-th falling edge, go to HOLD. mosi keeps the last bit.
- HOLD: wait H cycles, then:
  - drive ss=1 and mosi=0;
  - update rd_data;
  - pulse done[owner] for one cycle;
  - clear grant;
  - update last_grant;
  - go to GAP.
- GAP: wait H cycles with ss=1, then drop busy and return to IDLE. A request pending at that point is granted on the next IDLE edge.
- req is sampled only in IDLE. Dropping req mid-transaction does not abort; the transaction completes and done still pulses. wr_data is don't-care after grant.
- An internal bit counter is clog2(DATA_W+1) wide. An internal divider counter is clog2(CLK_DIV) wide (1 bit minimum) and wraps at H-1.

## Timing
- Reset values:
  - grant=0, done=0, rd_data=0, busy=0;
  - sclk=0, mosi=0, ss=1;
  - FSM=IDLE, last_grant=NUM_REQ-1, so requester 0 wins first.
- rst asserted mid-transaction: all of the above take effect on the next edge, the transfer is abandoned, and no done is issued.
- Grant latency: 1 cycle from req high in IDLE. ss falls on that same edge.
- Within a frame:
  - first sclk rise occurs H cycles after ss falls;
  - sclk edges are spaced H cycles apart;
  - ss-low duration is (2*DATA_W+1)*H cycles;
  - done coincides with the ss rising edge.
- Minimum ss-high time between frames: H+1 cycles.
- Back-to-back throughput for one requester: (2*DATA_W+2)*H+1 cycles per word.
- Simultaneous requests: exactly one grant. A continuously requesting set is served in strict rotation, with no starvation.

## Configuration
- SPI_ARB_FIXED_PRIO_EN defined: fixed priority replaces round-robin. The lowest set index in req always wins, and last_grant is not implemented.
- Not defined: round-robin as described above.
- All timing is identical in both builds.

## Structure
- Package spi_arb_pkg holds:
  - the FSM state enum (IDLE/SETUP/SHIFT/HOLD/GAP);
  - the mode-0 CPOL/CPHA constants;
  - a round-robin pick function (req vector plus last index returns a one-hot vector).
- One sub-module, spi_shift_engine, handles the divider, sclk generation, shift/sample registers and bit counter. It uses a start/word_in/finished/word_out handshake.
- The top level holds only arbitration, grant/done bookkeeping and the state sequencing around the engine.

## Test plan
- Single transfer: NUM_REQ=2, H=4, req[0]=1 with wr_data 16'hA5A5, slave returns 16'h3C3C.
  - mosi bitstream is A5A5 MSB first;
  - rd_data=16'h3C3C and done=2'b01 at ss rise;
  - ss low for 132 cycles.
- Contention: req=2'b11 held continuously. Grants alternate 01,10,01,10 and each done pulses to the matching owner.
- Reset mid-frame: assert rst after the 5th sclk rise. The next edge shows ss=1, sclk=0, mosi=0, grant=0, and no done pulse. Afterwards req[1] alone is granted within 1 cycle.
- Min divider: CLK_DIV=1, DATA_W=8, wr_data 8'h81. sclk toggles every cycle and the 8 bits arrive correctly at the slave BFM.
- Request withdrawn: req[1] drops 2 cycles after grant. The transaction still runs to completion and done[1] pulses.
- With SPI_ARB_FIXED_PRIO_EN: req=2'b11 held continuously, and requester 0 is granted every frame.
